// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding.
// Combinational helpers only; no latency, no flow control.
// The illegal encoding 2'd3 is folded back to IDLE by state_decode.
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [1:0] state_decode(input logic [1:0] st);
        return (st == 2'd3) ? ST_IDLE : st;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder cell shared by the serial controller.
// Purely combinational, zero latency; no flow control.
// Outputs follow the inputs with no stalling.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder cell walks the operands LSB first.
// Latency WIDTH+1 cycles start->done; start is ignored (not queued) while busy.
// sum/cout are updated only when a result completes and are held otherwise.
module serial_add_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       st;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Bit 0 of the sum shift register would be shifted out unread, so it is not kept.
    logic [WIDTH-1:1] s_sh;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             co;
    logic [WIDTH-1:0] s_nxt;

    full_adder_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (c),
        .s  (s),
        .co (co)
    );

    assign st    = state_decode(state);
    assign s_nxt = {s, s_sh};
    assign busy  = (st == ST_RUN);
    assign done  = (st == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c     <= cin;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    s_sh <= s_nxt[WIDTH-1:1];
                    c    <= co;
                    if (cnt == LAST) begin
                        sum   <= s_nxt;
                        cout  <= co;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
